// File: rtl/ipml_fifo_pkg.sv
// Shared constants for the single-clock FIFO: level width helper, read-mode
// encodings and the reset values of the status outputs.
package ipml_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam logic WR_FULL_RST      = 1'b0;
    localparam logic ALMOST_FULL_RST  = 1'b0;
    localparam logic RD_EMPTY_RST     = 1'b1;
    localparam logic ALMOST_EMPTY_RST = 1'b1;
    localparam logic WR_OVERFLOW_RST  = 1'b0;
    localparam logic RD_UNDERFLOW_RST = 1'b0;

    // Pointers and the level carry one extra wrap bit above the address.
    function automatic int level_width(input int depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/ipml_sync_fifo_ram.sv
// Simple dual-port RAM for the FIFO: one write port, one registered read port
// with read enable. Only the output register is reset; the array is not.
module ipml_sync_fifo_ram #(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [c_ADDR_WIDTH-1:0] wr_addr,
    input  logic [c_DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [c_ADDR_WIDTH-1:0] rd_addr,
    output logic [c_DATA_WIDTH-1:0] rd_data
);

    logic [c_DATA_WIDTH-1:0] mem [2**c_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ipml_sync_fifo_v2_0.sv
// Single-clock FIFO with standard or first-word-fall-through read, level and
// threshold flags. Sticky error flags are built only with IPML_SYNC_FIFO_ERR_FLAG_EN.
module ipml_sync_fifo_v2_0
    import ipml_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_FWFT_EN          = 0,
    parameter int c_ALMOST_FULL_NUM  = 1020,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    input  logic                     rd_en,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     wr_overflow,
    output logic                     rd_underflow,
    input  logic                     err_clr
);

    localparam int LW = level_width(c_DEPTH_WIDTH);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(2 ** c_DEPTH_WIDTH);
    localparam logic [LW-1:0] AF_LVL    = LW'(c_ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_LVL    = LW'(c_ALMOST_EMPTY_NUM);

    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] wr_ptr_nxt;
    logic [LW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic          wr_acc;
    logic          rd_acc;
    logic          ram_rd;
    logic          stage_nxt;

    assign wr_acc     = wr_en & ~wr_full;
    assign wr_ptr_nxt = wr_ptr + LW'(wr_acc);
    assign rd_ptr_nxt = rd_ptr + LW'(ram_rd);
    // Words in the RAM plus the word parked in the FWFT output stage.
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt + LW'(stage_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            water_level  <= '0;
            wr_full      <= WR_FULL_RST;
            almost_full  <= ALMOST_FULL_RST;
            almost_empty <= ALMOST_EMPTY_RST;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            water_level  <= level_nxt;
            wr_full      <= (level_nxt == DEPTH_LVL);
            almost_full  <= (level_nxt >= AF_LVL);
            almost_empty <= (level_nxt <= AE_LVL);
        end
    end

    generate
        if (c_FWFT_EN == FIFO_MODE_FWFT) begin : g_fwft
            logic out_valid;

            // RAM output register is the head stage; refill it whenever it
            // is empty or being popped so a steady stream has no bubbles.
            assign rd_acc    = rd_en & out_valid;
            assign ram_rd    = (wr_ptr != rd_ptr) & (~out_valid | rd_acc);
            assign stage_nxt = ram_rd | (out_valid & ~rd_acc);
            assign rd_empty  = ~out_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= ~RD_EMPTY_RST;
                end else begin
                    out_valid <= stage_nxt;
                end
            end
        end else begin : g_std
            logic empty_q;

            assign rd_acc    = rd_en & ~empty_q;
            assign ram_rd    = rd_acc;
            assign stage_nxt = 1'b0;
            assign rd_empty  = empty_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    empty_q <= RD_EMPTY_RST;
                end else begin
                    empty_q <= (level_nxt == '0);
                end
            end
        end
    endgenerate

    ipml_sync_fifo_ram #(
        .c_DATA_WIDTH (c_DATA_WIDTH),
        .c_ADDR_WIDTH (c_DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[c_DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr[c_DEPTH_WIDTH-1:0]),
        .rd_data (rd_data)
    );

`ifdef IPML_SYNC_FIFO_ERR_FLAG_EN
    // Clear wins over a set arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_overflow  <= WR_OVERFLOW_RST;
            rd_underflow <= RD_UNDERFLOW_RST;
        end else if (err_clr) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            if (wr_en && wr_full) begin
                wr_overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign wr_overflow    = WR_OVERFLOW_RST;
    assign rd_underflow   = RD_UNDERFLOW_RST;
`endif

endmodule

// File: tb/tb_ipml_sync_fifo_v2_0.sv
// Bench for ipml_sync_fifo_v2_0: a standard and an FWFT instance share the
// same stimulus and are compared every cycle against queue-based models.
module tb_ipml_sync_fifo_v2_0;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
`ifdef IPML_SYNC_FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       rd_en;
    logic       err_clr;

    logic       s_wr_full, s_af, s_rd_empty, s_ae, s_ovf, s_udf;
    logic [7:0] s_rd_data;
    logic [4:0] s_level;
    logic       f_wr_full, f_af, f_rd_empty, f_ae, f_ovf, f_udf;
    logic [7:0] f_rd_data;
    logic [4:0] f_level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ipml_sync_fifo_v2_0 #(
        .c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT_EN(0),
        .c_ALMOST_FULL_NUM(AF), .c_ALMOST_EMPTY_NUM(AE)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(s_wr_full), .almost_full(s_af), .rd_data(s_rd_data),
        .rd_en(rd_en), .rd_empty(s_rd_empty), .almost_empty(s_ae),
        .water_level(s_level), .wr_overflow(s_ovf), .rd_underflow(s_udf),
        .err_clr(err_clr)
    );

    ipml_sync_fifo_v2_0 #(
        .c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT_EN(1),
        .c_ALMOST_FULL_NUM(AF), .c_ALMOST_EMPTY_NUM(AE)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(f_wr_full), .almost_full(f_af), .rd_data(f_rd_data),
        .rd_en(rd_en), .rd_empty(f_rd_empty), .almost_empty(f_ae),
        .water_level(f_level), .wr_overflow(f_ovf), .rd_underflow(f_udf),
        .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every held word in a queue tagged with the edge that accepted it.
    // An FWFT word is readable from the edge after its acceptance onward.
    typedef struct {
        logic [7:0] d;
        int         cyc;
    } ent_t;

    ent_t       mq_s[$];
    ent_t       mq_f[$];
    int         edge_cnt = 0;
    logic [7:0] m_rd_s   = 8'h00;
    bit         m_ovf_s = 0, m_udf_s = 0, m_ovf_f = 0, m_udf_f = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_s.delete();
            mq_f.delete();
            m_rd_s  = 8'h00;
            m_ovf_s = 0; m_udf_s = 0; m_ovf_f = 0; m_udf_f = 0;
        end else begin : m_step
            bit   s_full, s_empty, f_full, f_vis;
            ent_t e;
            s_full  = (mq_s.size() == DEPTH);
            s_empty = (mq_s.size() == 0);
            f_full  = (mq_f.size() == DEPTH);
            f_vis   = (mq_f.size() > 0) && (mq_f[0].cyc < edge_cnt);
            edge_cnt++;
            if (ERR_EN) begin
                if (err_clr) begin
                    m_ovf_s = 0; m_udf_s = 0; m_ovf_f = 0; m_udf_f = 0;
                end else begin
                    if (wr_en && s_full)  m_ovf_s = 1;
                    if (rd_en && s_empty) m_udf_s = 1;
                    if (wr_en && f_full)  m_ovf_f = 1;
                    if (rd_en && !f_vis)  m_udf_f = 1;
                end
            end
            e.d   = wr_data;
            e.cyc = edge_cnt;
            if (rd_en && !s_empty) begin
                m_rd_s = mq_s[0].d;
                void'(mq_s.pop_front());
            end
            if (wr_en && !s_full) mq_s.push_back(e);
            if (rd_en && f_vis) void'(mq_f.pop_front());
            if (wr_en && !f_full) mq_f.push_back(e);
        end
    end

    always @(negedge clk) begin : compare
        int          ss, fs;
        bit          fvis;
        logic [10:0] e_s, e_f;
        ss   = mq_s.size();
        fs   = mq_f.size();
        fvis = (fs > 0) && (mq_f[0].cyc < edge_cnt);
        e_s  = {5'(ss), ss == DEPTH, ss >= AF, ss <= AE, ss == 0, m_ovf_s, m_udf_s};
        e_f  = {5'(fs), fs == DEPTH, fs >= AF, fs <= AE, !fvis, m_ovf_f, m_udf_f};
        chk("std_status",
            32'({s_level, s_wr_full, s_af, s_ae, s_rd_empty, s_ovf, s_udf}), 32'(e_s));
        chk("std_rd_data", 32'(s_rd_data), 32'(m_rd_s));
        chk("fwft_status",
            32'({f_level, f_wr_full, f_af, f_ae, f_rd_empty, f_ovf, f_udf}), 32'(e_f));
        if (fvis) chk("fwft_rd_data", 32'(f_rd_data), 32'(mq_f[0].d));
    end

    task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 32'(s_level), 0);
        chk("rst_flags", 32'({s_rd_empty, s_ae, s_wr_full, s_af, s_ovf, s_udf}), 32'b110000);
        chk("rst_rd_data", 32'(s_rd_data), 0);
        rst_n = 1'b1;

        // Fill to capacity, then one dropped write.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_level", 32'(s_level), 32'(i + 1));
            chk("fill_af", 32'(s_af), 32'((i + 1) >= 14));
        end
        chk("fill_full_s", 32'(s_wr_full), 1);
        chk("fill_full_f", 32'({f_wr_full, f_level}), 32'h30);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_level", 32'(s_level), 16);
        chk("ovf_flag", 32'({s_ovf, f_ovf}), ERR_EN ? 32'b11 : 32'b00);

        // Drain everything; standard data trails rd_en by one edge.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", 32'(s_rd_data), 32'(i));
        end
        chk("drain_empty", 32'({s_rd_empty, f_rd_empty}), 32'b11);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_flag", 32'({s_udf, f_udf}), ERR_EN ? 32'b11 : 32'b00);
        chk("udf_hold", 32'(s_rd_data), 32'h0F);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_flags", 32'({s_ovf, s_udf, f_ovf, f_udf}), 0);

        // Write-to-visibility latency.
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        chk("vis_std", 32'(s_rd_empty), 0);
        chk("vis_fwft_early", 32'(f_rd_empty), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("vis_fwft", 32'({f_rd_empty, f_rd_data}), 32'h055);

        // Continuous streaming through the FWFT stage.
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream_fwft", 32'({f_rd_empty, f_rd_data}), 32'(i - 1));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_tail", 32'({f_rd_empty, f_rd_data}), 32'h01F);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_end", 32'({s_rd_empty, s_rd_data}), 32'h11F);

        // Full with simultaneous write and read.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        chk("both_full_level", 32'({s_level, f_level}), 32'({5'd15, 5'd15}));
        chk("both_full_ovf", 32'(s_ovf), 32'(ERR_EN));
        chk("both_full_data", 32'(s_rd_data), 32'h60);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'({s_ovf, f_ovf}), 0);
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("no_77", 32'({s_rd_empty, s_rd_data}), 32'h16F);

        // Wrap-around at a steady level of 8.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'(8'h90 + i), 1'b1, 1'b0);
            chk("wrap_data", 32'(s_rd_data), (i < 8) ? 32'(8'h80 + i) : 32'(8'h90 + i - 8));
        end
        chk("wrap_level", 32'({s_level, f_level}), 32'({5'd8, 5'd8}));
        chk("wrap_flags", 32'({s_wr_full, s_rd_empty, f_rd_empty, s_ovf, s_udf}), 0);
        for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_last", 32'({s_rd_empty, s_rd_data}), 32'h1B7);

        // Asynchronous reset mid-stream at level 9.
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(s_level), 9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_std", 32'({s_level, s_rd_empty, s_ae, s_wr_full}), 32'b0000_0_110);
        chk("arst_fwft", 32'({f_level, f_rd_empty, f_ae, f_wr_full}), 32'b0000_0_110);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        chk("post_rst_level", 32'(s_level), 3);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data0", 32'(s_rd_data), 32'hD0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data2", 32'({s_rd_empty, s_rd_data}), 32'h1D2);
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ipml_sync_fifo_v2_0.md
Name: ipml_sync_fifo_v2_0

Overview:
- Single-clock FIFO; next generation of the dual-clock FIFO wrapper for same-domain buffering.
- Parametrised width and depth.
- Selectable standard or first-word-fall-through (FWFT) read mode, plus threshold flags and an occupancy level.
- Storage is an inferred simple-dual-port RAM; the controller is folded into this block (no gray-code crossing).

Parameters:
- c_DATA_WIDTH, 32: word width, 1..1152.
- c_DEPTH_WIDTH, 10: log2 of depth, 4..20; DEPTH = 2^c_DEPTH_WIDTH.
- c_FWFT_EN, 0: 0 = standard read (data one cycle after rd_en); 1 = FWFT.
- c_ALMOST_FULL_NUM, 1020: almost_full asserted when level >= this value.
- c_ALMOST_EMPTY_NUM, 4: almost_empty asserted when level <= this value.

Ports:
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  c_DATA_WIDTH  write word.
- wr_en  in  1  write request.
- wr_full  out  1  FIFO full.
- almost_full  out  1  level >= c_ALMOST_FULL_NUM.
- rd_data  out  c_DATA_WIDTH  read word.
- rd_en  in  1  read request / pop.
- rd_empty  out  1  no readable word.
- almost_empty  out  1  level <= c_ALMOST_EMPTY_NUM.
- water_level  out  c_DEPTH_WIDTH+1  words held.
- wr_overflow  out  1  sticky: write attempted while full.
- rd_underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  synchronous clear of the sticky flags.

Behaviour:
- Reset (rst_n=0, asynchronous): pointers, level and rd_data = 0; rd_empty = 1; almost_empty = 1; wr_full = 0; almost_full = 0; wr_overflow = 0; rd_underflow = 0. Release is synchronous to clk; the RAM contents are not cleared.
- Pointers: c_DEPTH_WIDTH+1 bits, binary, with a wrap bit.
  - full = same address and wrap bits differ; empty = pointers equal.
  - Natural wrap at DEPTH; no special case at the boundary.
- Write: accepted when wr_en=1 and wr_full=0 (the registered value). A write while full is dropped, even if a read occurs in the same cycle.
- Read, standard mode:
  - accepted when rd_en=1 and rd_empty=0;
  - rd_data is updated on the next edge (latency 1) and holds its value otherwise;
  - a read while empty leaves rd_data unchanged.
- Read, FWFT mode:
  - a one-word output stage holds the head word; rd_empty=0 means rd_data is valid now;
  - rd_en pops it, and the next word appears the following cycle without a bubble while the RAM is non-empty;
  - into an empty FIFO, a write at edge N gives rd_empty=0 with valid rd_data after edge N+2;
  - the output stage counts toward water_level and capacity, so total capacity stays DEPTH.
- Write-to-visibility, standard mode: a write at edge N gives rd_empty=0 after edge N+1.
- Level and flags: level +1 on an accepted write only, -1 on an accepted read only, unchanged on both. All flags are registered from the next-state level, so they are consistent with water_level in the same cycle.
- Boundaries:
  - Full with simultaneous wr_en and rd_en: the read is accepted, the write is dropped; level goes DEPTH to DEPTH-1 and wr_overflow is set.
  - Empty with simultaneous wr_en and rd_en: the write is accepted, the read is ignored; rd_underflow is set.
  - err_clr has priority over a set in the same cycle.
- Reset mid-burst: the FIFO returns immediately to the empty state; in-flight words are discarded.

Optional Feature:
- Macro IPML_SYNC_FIFO_ERR_FLAG_EN.
- Defined: wr_overflow and rd_underflow sticky registers are built as described above, cleared by err_clr or reset.
- Undefined: both outputs are tied to 0, err_clr is ignored, and no flag flops are synthesised. FIFO behaviour is otherwise identical.

Decomposition:
- Package ipml_fifo_pkg holds:
  - level-width helper (c_DEPTH_WIDTH+1);
  - read-mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - reset values for the flag outputs.
- One sub-module: ipml_sync_fifo_ram, a simple-dual-port RAM with registered read, 1-cycle latency, with read enable and no reset on the array.
- Pointers, level, flags and the FWFT output stage stay in the top module.

Test Plan (bench uses c_DEPTH_WIDTH=4, DEPTH=16, AF=14, AE=2, width 8):
- Reset, then 16 writes 0x00..0x0F → wr_full=1 after the 16th edge, level=16, almost_full from level 14; a 17th write of 0xAA is dropped and wr_overflow=1.
- Standard mode, drain 16 reads → rd_data = 0x00..0x0F, each one cycle after its rd_en; rd_empty=1 after the last; a 17th read gives rd_underflow=1 and rd_data stays 0x0F.
- FWFT mode, write 0x55 at edge N into an empty FIFO → rd_empty=0 and rd_data=0x55 after edge N+2; continuous rd_en with writes streams 0x00..0x1F with no bubbles.
- At level 16, simultaneous wr_en (0x77) and rd_en → level=15, 0x77 not stored, wr_overflow=1; then err_clr=1 → flag cleared next cycle.
- Wrap-around: 40 interleaved write/read pairs at level 8 → level stays 8, data order preserved across the pointer wrap, no flag toggles.
- Assert rst_n=0 mid-stream at level 9 → immediately level=0, rd_empty=1, almost_empty=1, wr_full=0; writes after release restart at address 0.
